nonce_hub: RTL and testbench
============================

Name: nonce_hub

Overview:
- Parametrised successor to the single-slave ticket/hub path.
- Collects golden nonces from CHANNELS independent hash cores, each running on its own DCM clock domain.
- Synchronises each core's ticket into the comm clock and buffers nonces in a FIFO with a round-robin arbiter.
- Drives the serial core's send handshake one word at a time. Sits between the sha256_top instances and serial_core.

Parameters:
- CHANNELS, 4, number of hash cores (1..16).
- FIFO_DEPTH, 8, nonce FIFO entries; must be a power of 2, minimum 2.
- NONCE_WIDTH, 32, bits per nonce.
- BUSY_TIMEOUT, 15, cycles the TX FSM waits for serial_busy to rise before giving up.
- Localparam ID_BITS = max(1, clog2(CHANNELS)). Localparam CNT_BITS = clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  comm clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high.
- ticket  in  CHANNELS  per-core got_ticket level from the hash-clock domain.
- nonces  in  CHANNELS*NONCE_WIDTH  channel i occupies [i*NONCE_WIDTH +: NONCE_WIDTH]; must be stable while ticket[i] is high.
- serial_busy  in  1  UART transmitting.
- serial_send  out  1  one-cycle pulse that starts the UART.
- word  out  NONCE_WIDTH  nonce presented to the UART; holds its value until the next send.
- word_chan  out  ID_BITS  channel that produced word.
- new_nonce  out  1  one-cycle pulse per FIFO push; drives the LED fader.
- fifo_count  out  CNT_BITS  current FIFO occupancy.
- lost_count  out  16  saturating count of nonces lost to overwrite.

Behaviour:
Reset:
- Asynchronous, active-high.
- Clears synchronisers, pending, hold, FIFO pointers and rr pointer; TX FSM goes to IDLE.
- Outputs after reset: serial_send=0, word=0, word_chan=0, new_nonce=0, fifo_count=0, lost_count=0.
- Reset asserted mid-send aborts the send; the FIFO contents are discarded.

Capture:
- ticket[i] passes through a 2-flop synchroniser, then a rising-edge detector. The edge is seen in cycle E = T+2, where T is the first clk edge that samples ticket high.
- In cycle E, nonces[i] is latched into hold[i] and pending[i] is set.
- Edge on channel i while pending[i]=1 and i is not granted that cycle: hold[i] is overwritten and lost_count increments. lost_count saturates at 0xFFFF.
- Edge on channel i in the same cycle channel i is granted: the old hold[i] is pushed, the new nonce is latched, pending[i] stays 1, and lost_count is not incremented.

Arbiter and FIFO:
- Each cycle with any pending bit set and FIFO not full: grant the first pending channel at or after rr, searching cyclically.
- On grant: push {g, hold[g]}, clear pending[g], set rr = (g+1) mod CHANNELS, pulse new_nonce.
- At most one push per cycle.
- FIFO full: no grant; pending bits hold their state, so nothing is lost except through overwrite.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.

TX FSM (IDLE, WAIT_BUSY, WAIT_DONE):
- IDLE: if FIFO not empty and serial_busy=0, then:
  - word/word_chan take the FIFO head;
  - pop the FIFO;
  - serial_send=1 for this cycle;
  - go to WAIT_BUSY.
- WAIT_BUSY: serial_busy=1 goes to WAIT_DONE. After BUSY_TIMEOUT cycles without busy, go to IDLE; the word is considered sent.
- WAIT_DONE: serial_busy=0 goes to IDLE.

Latency:
- Empty FIFO, idle TX: push at E+1, serial_send at E+2.

Optional Feature:
- Macro NONCE_HUB_DEDUP_EN.
- Defined:
  - The hub keeps last_pushed (NONCE_WIDTH bits, reset 0) and a last_valid flag (reset 0).
  - A granted candidate equal to last_pushed while last_valid=1 is discarded: pending is cleared and rr advances, but there is no push and no new_nonce pulse.
  - Dedup compares nonce only, not channel.
- Undefined: every grant is pushed, and the dedup registers are not present.

Test Plan:
- Single nonce: CHANNELS=4, ticket[2] rises with nonce 0xDEADBEEF, serial_busy answered 1 cycle after send and held 10 cycles → one new_nonce pulse; serial_send at E+2; word=0xDEADBEEF, word_chan=2; fifo_count returns to 0.
- Simultaneous tickets: all 4 channels rise together with nonces 0x10..0x13, rr=0 → words sent in order ch0,1,2,3; next burst starts at ch0 again because rr has wrapped.
- Full FIFO: FIFO_DEPTH=2, serial_busy held 1, 4 tickets on distinct channels → fifo_count=2, two channels stay pending, lost_count=0; releasing busy drains all 4.
- Overwrite: ticket[1] toggled twice (0xA, then 0xB) while the FIFO is full → lost_count=1; the word later sent for ch1 is 0xB.
- Timeout and reset: serial_busy never rises → FSM returns to IDLE after 15 cycles and the next word is sent. Reset asserted during WAIT_DONE → outputs zero immediately, fifo_count=0.
- Dedup (NONCE_HUB_DEDUP_EN defined): ch0 and ch3 both report 0x55 → one push, one serial_send. Macro undefined → two sends.

Source files
------------

// File: rtl/nonce_hub.sv
// nonce_hub: gathers golden nonces from CHANNELS hash cores, queues them and hands them to serial_core.
// Optional build macro NONCE_HUB_DEDUP_EN drops a grant whose nonce equals the last pushed nonce.
module nonce_hub #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned NONCE_WIDTH  = 32,
    parameter int unsigned BUSY_TIMEOUT = 15,
    localparam int unsigned ID_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNT_BITS    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             ticket,
    input  logic [CHANNELS*NONCE_WIDTH-1:0] nonces,
    input  logic                            serial_busy,
    output logic                            serial_send,
    output logic [NONCE_WIDTH-1:0]          word,
    output logic [ID_BITS-1:0]              word_chan,
    output logic                            new_nonce,
    output logic [CNT_BITS-1:0]             fifo_count,
    output logic [15:0]                     lost_count
);

    localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_BITS = ID_BITS + NONCE_WIDTH;
    localparam int unsigned SUM_BITS   = ID_BITS + 1;
    localparam int unsigned LEV_BITS   = $clog2(CHANNELS + 1);
    localparam int unsigned TMO_BITS   = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_e;

    logic [CHANNELS-1:0]    sync1_q, sync2_q, prev_q, rise_c;
    logic [CHANNELS-1:0]    pending_q, pending_d;
    logic [NONCE_WIDTH-1:0] hold_q [CHANNELS];
    logic [NONCE_WIDTH-1:0] hold_d [CHANNELS];
    logic [ID_BITS-1:0]     rr_q, rr_d;
    logic                   gnt_valid_c;
    logic [ID_BITS-1:0]     gnt_idx_c, idx_c;
    logic [SUM_BITS-1:0]    idx_sum;
    logic                   push_c, pop_c;
    logic [ENTRY_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [ENTRY_BITS-1:0]  head_c;
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]    count_q, count_d;
    logic [LEV_BITS-1:0]    lost_ev;
    logic [16:0]            lost_sum;
    logic [15:0]            lost_q, lost_d;
    logic                   new_nonce_q;
    tx_state_e              state_q, state_d;
    logic [TMO_BITS-1:0]    tmo_q, tmo_d;
    logic                   send_q, send_d;
    logic [NONCE_WIDTH-1:0] word_q, word_d;
    logic [ID_BITS-1:0]     word_chan_q, word_chan_d;

    assign rise_c = sync2_q & ~prev_q;
    assign head_c = mem_q[rd_ptr_q];

    // Round-robin search: first pending channel at or after rr, only while the FIFO has room.
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        idx_sum     = '0;
        idx_c       = '0;
        if (count_q != CNT_BITS'(FIFO_DEPTH)) begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx_sum = SUM_BITS'(rr_q) + SUM_BITS'(k);
                if (idx_sum >= SUM_BITS'(CHANNELS)) begin
                    idx_sum = idx_sum - SUM_BITS'(CHANNELS);
                end
                idx_c = idx_sum[ID_BITS-1:0];
                if (pending_q[idx_c] && !gnt_valid_c) begin
                    gnt_valid_c = 1'b1;
                    gnt_idx_c   = idx_c;
                end
            end
        end
    end

`ifdef NONCE_HUB_DEDUP_EN
    logic [NONCE_WIDTH-1:0] last_pushed_q, last_pushed_d;
    logic                   last_valid_q, last_valid_d;

    always_comb begin
        push_c        = gnt_valid_c && !(last_valid_q && (hold_q[gnt_idx_c] == last_pushed_q));
        last_pushed_d = last_pushed_q;
        last_valid_d  = last_valid_q;
        if (push_c) begin
            last_pushed_d = hold_q[gnt_idx_c];
            last_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pushed_q <= '0;
            last_valid_q  <= 1'b0;
        end else begin
            last_pushed_q <= last_pushed_d;
            last_valid_q  <= last_valid_d;
        end
    end
`else
    assign push_c = gnt_valid_c;
`endif

    // Capture: a rising ticket latches the nonce; re-arming a still-pending, ungranted slot loses the old one.
    always_comb begin
        pending_d = pending_q;
        hold_d    = hold_q;
        lost_ev   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rise_c[i]) begin
                hold_d[i]    = nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(gnt_valid_c && (gnt_idx_c == ID_BITS'(i)))) begin
                    lost_ev = lost_ev + LEV_BITS'(1);
                end
            end else if (gnt_valid_c && (gnt_idx_c == ID_BITS'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
        lost_sum = 17'(lost_q) + 17'(lost_ev);
        lost_d   = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (gnt_valid_c) begin
            rr_d = (gnt_idx_c == ID_BITS'(CHANNELS - 1)) ? '0 : gnt_idx_c + ID_BITS'(1);
        end
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // TX FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // TX FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !serial_busy) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (serial_busy)                                  state_d = WAIT_DONE;
                else if (tmo_q == TMO_BITS'(BUSY_TIMEOUT - 1))    state_d = IDLE;
            end
            WAIT_DONE: begin
                if (!serial_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // TX FSM: outputs and pop.
    always_comb begin
        pop_c       = 1'b0;
        send_d      = 1'b0;
        word_d      = word_q;
        word_chan_d = word_chan_q;
        tmo_d       = '0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !serial_busy) begin
                    pop_c       = 1'b1;
                    send_d      = 1'b1;
                    word_chan_d = head_c[ENTRY_BITS-1 -: ID_BITS];
                    word_d      = head_c[NONCE_WIDTH-1:0];
                end
            end
            WAIT_BUSY: tmo_d = tmo_q + TMO_BITS'(1);
            default:   tmo_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {gnt_idx_c, hold_q[gnt_idx_c]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lost_q      <= '0;
            new_nonce_q <= 1'b0;
            tmo_q       <= '0;
            send_q      <= 1'b0;
            word_q      <= '0;
            word_chan_q <= '0;
        end else begin
            sync1_q     <= ticket;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lost_q      <= lost_d;
            new_nonce_q <= push_c;
            tmo_q       <= tmo_d;
            send_q      <= send_d;
            word_q      <= word_d;
            word_chan_q <= word_chan_d;
        end
    end

    assign serial_send = send_q;
    assign word        = word_q;
    assign word_chan   = word_chan_q;
    assign new_nonce   = new_nonce_q;
    assign fifo_count  = count_q;
    assign lost_count  = lost_q;

endmodule

// File: tb/tb_nonce_hub.sv
// Self-checking bench for nonce_hub: table of ticket vectors with a send scoreboard,
// plus hand sequences for full FIFO / overwrite, busy timeout and mid-send reset.
module tb_nonce_hub;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ticket;
    logic [127:0] nonces;
    logic         serial_busy;
    logic         serial_send;
    logic [31:0]  word;
    logic [1:0]   word_chan;
    logic         new_nonce;
    logic [1:0]   fifo_count;
    logic [15:0]  lost_count;

    nonce_hub #(
        .CHANNELS(4), .FIFO_DEPTH(2), .NONCE_WIDTH(32), .BUSY_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .ticket(ticket), .nonces(nonces),
        .serial_busy(serial_busy), .serial_send(serial_send), .word(word),
        .word_chan(word_chan), .new_nonce(new_nonce), .fifo_count(fifo_count),
        .lost_count(lost_count)
    );

    initial forever #5 clk = ~clk;

`ifdef NONCE_HUB_DEDUP_EN
    localparam int DUP_PUSHES = 1;
`else
    localparam int DUP_PUSHES = 2;
`endif

    typedef struct packed {
        logic [1:0]  chan;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [3:0]   mask;
        logic [127:0] nv;
        int           exp_pushes;
        int           exp_lost;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          nn_count = 0;
    int          send_count = 0;
    int          first_nn = -1;
    int          first_send = -1;
    int          prev_send = 0;
    int          last_send = 0;
    int          rr_m = 0;
    logic [31:0] lp = '0;
    bit          lv = 1'b0;
    bit          busy_auto = 1'b1;
    bit          busy_force = 1'b0;
    int          n0;
    int          snap;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Reference model: all masked channels rise together, granted in rotation from rr.
    function automatic void model_expect(input logic [3:0] mask, input logic [127:0] nv);
        int          start;
        int          c;
        logic [31:0] n;
        bit          skip;
        start = rr_m;
        for (int k = 0; k < 4; k++) begin
            c = (start + k) % 4;
            if (mask[c]) begin
                rr_m = (c + 1) % 4;
                n    = nv[c*32 +: 32];
                skip = 1'b0;
`ifdef NONCE_HUB_DEDUP_EN
                skip = lv && (n == lp);
`endif
                if (!skip) begin
                    exp_q.push_back({2'(c), n});
                    lp = n;
                    lv = 1'b1;
                end
            end
        end
    endfunction

    task automatic pulse(input logic [3:0] mask, input logic [127:0] nv);
        nonces = nv;
        ticket = mask;
        repeat (4) @(negedge clk);
        ticket = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_vec(input logic [3:0] mask, input logic [127:0] nv, output int start_cyc);
        first_nn   = -1;
        first_send = -1;
        nn_count   = 0;
        model_expect(mask, nv);
        start_cyc = cyc;
        pulse(mask, nv);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_count != 2'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d words still expected after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (30) @(negedge clk);
    endtask

    // Serial UART stand-in: answers a send with busy one cycle later, or is forced busy / silent.
    initial begin
        serial_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_force) begin
                serial_busy = 1'b1;
            end else if (busy_auto && serial_send === 1'b1) begin
                serial_busy = 1'b1;
                repeat (10) @(negedge clk);
                serial_busy = 1'b0;
            end else begin
                serial_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every send must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (new_nonce === 1'b1) begin
                    nn_count++;
                    if (first_nn < 0) first_nn = cyc;
                end
                if (serial_send === 1'b1) begin
                    send_count++;
                    prev_send = last_send;
                    last_send = cyc;
                    if (first_send < 0) first_send = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_send: got chan %0d word %0h, required no send", word_chan, word);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("send_word", 64'(word), 64'(mon_e.word));
                        chk("send_chan", 64'(word_chan), 64'(mon_e.chan));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0100, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1, 0};
        tbl[1] = '{4'b1000, {32'h33, 32'h0, 32'h0, 32'h0}, 1, 0};
        tbl[2] = '{4'b1111, {32'h13, 32'h12, 32'h11, 32'h10}, 4, 0};
        tbl[3] = '{4'b1111, {32'h23, 32'h22, 32'h21, 32'h20}, 4, 0};
        tbl[4] = '{4'b1001, {32'h55, 32'h0, 32'h0, 32'h55}, DUP_PUSHES, 0};
        tbl[5] = '{4'b0110, {32'h0, 32'h72, 32'h71, 32'h0}, 2, 0};
        tbl[6] = '{4'b1000, {32'h99, 32'h0, 32'h0, 32'h0}, 1, 0};

        reset  = 1'b1;
        ticket = '0;
        nonces = '0;
        repeat (3) @(negedge clk);
        chk("rst_send", 64'(serial_send), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_chan", 64'(word_chan), 64'd0);
        chk("rst_new_nonce", 64'(new_nonce), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_lost", 64'(lost_count), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            drive_vec(tbl[v].mask, tbl[v].nv, n0);
            wait_drain(400, "vec");
            chk("vec_pushes", 64'(nn_count), 64'(tbl[v].exp_pushes));
            chk("vec_push_latency", 64'(first_nn), 64'(n0 + 4));
            chk("vec_send_latency", 64'(first_send), 64'(n0 + 5));
            chk("vec_fifo_empty", 64'(fifo_count), 64'd0);
            chk("vec_lost", 64'(lost_count), 64'(tbl[v].exp_lost));
        end

        // FIFO full with the UART busy, then overwrite ch1 while it waits.
        busy_auto  = 1'b0;
        busy_force = 1'b1;
        repeat (3) @(negedge clk);
        nn_count = 0;
        model_expect(4'b1111, {32'h43, 32'h42, 32'h41, 32'h40});
        pulse(4'b1111, {32'h43, 32'h42, 32'h41, 32'h40});
        repeat (6) @(negedge clk);
        chk("full_count", 64'(fifo_count), 64'd2);
        chk("full_pushes", 64'(nn_count), 64'd2);
        chk("full_lost", 64'(lost_count), 64'd0);
        pulse(4'b0010, {32'h0, 32'h0, 32'hA, 32'h0});
        pulse(4'b0010, {32'h0, 32'h0, 32'hB, 32'h0});
        repeat (4) @(negedge clk);
        chk("overwrite_lost", 64'(lost_count), 64'd1);
        chk("overwrite_count", 64'(fifo_count), 64'd2);
        exp_q.push_back({2'd1, 32'hB});
        rr_m = 2;
        lp   = 32'hB;
        lv   = 1'b1;
        busy_force = 1'b0;
        busy_auto  = 1'b1;
        wait_drain(600, "full");
        chk("full_total_pushes", 64'(nn_count), 64'd5);
        chk("full_lost_after", 64'(lost_count), 64'd1);

        // UART never raises busy: each word waits out the timeout.
        busy_auto = 1'b0;
        repeat (3) @(negedge clk);
        drive_vec(4'b0011, {32'h0, 32'h0, 32'h71, 32'h70}, n0);
        wait_drain(400, "timeout");
        chk("timeout_pushes", 64'(nn_count), 64'd2);
        chk("timeout_gap", 64'(last_send - prev_send), 64'd16);

        // Reset while the UART is mid-word.
        busy_auto = 1'b1;
        repeat (3) @(negedge clk);
        drive_vec(4'b1100, {32'h81, 32'h80, 32'h0, 32'h0}, n0);
        chk("pre_reset_send_latency", 64'(first_send), 64'(n0 + 5));
        chk("pre_reset_word", 64'(word), 64'h80);
        chk("pre_reset_count", 64'(fifo_count), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_send", 64'(serial_send), 64'd0);
        chk("mid_rst_word", 64'(word), 64'd0);
        chk("mid_rst_chan", 64'(word_chan), 64'd0);
        chk("mid_rst_new_nonce", 64'(new_nonce), 64'd0);
        chk("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_lost", 64'(lost_count), 64'd0);
        exp_q.delete();
        rr_m = 0;
        lp   = '0;
        lv   = 1'b0;
        snap = send_count;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_no_send", 64'(send_count), 64'(snap));
        chk("post_rst_fifo", 64'(fifo_count), 64'd0);

        drive_vec(4'b0010, {32'h0, 32'h0, 32'h5A5A, 32'h0}, n0);
        wait_drain(400, "post_rst");
        chk("post_rst_pushes", 64'(nn_count), 64'd1);
        chk("post_rst_send_latency", 64'(first_send), 64'(n0 + 5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
